outer_product_accum: RTL



---
 rtl/opa_pkg.sv | 39 +++
 rtl/opa_requant.sv | 40 ++++
 rtl/outer_product_accum.sv | 103 ++++++++++
 3 files changed

// File: rtl/opa_pkg.sv
// Shared types, sizes and saturating arithmetic for the outer-product accumulator.
package opa_pkg;

    localparam int ROWS  = 15;
    localparam int COLS  = 16;
    localparam int DW    = 8;
    localparam int ACC_W = 20;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} opa_state_t;

    typedef logic signed [DW-1:0]    elem_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    typedef struct packed {
        logic ovf;
        acc_t sum;
    } sat_res_t;

    localparam acc_t ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam acc_t ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    function automatic acc_t sext(elem_t e);
        return acc_t'(e);
    endfunction

    // One extra bit catches the carry; top two bits disagreeing means overflow.
    function automatic sat_res_t sat_add(acc_t a, acc_t b);
        logic signed [ACC_W:0] s;
        sat_res_t r;
        s     = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        r.ovf = s[ACC_W] ^ s[ACC_W-1];
        if (r.ovf)
            r.sum = s[ACC_W] ? ACC_MIN : ACC_MAX;
        else
            r.sum = s[ACC_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/opa_requant.sv
// Per-element requantizer: round half up, arithmetic shift, saturate to int8.
// Optional OPA_RELU_EN clamps negative results to zero.
module opa_requant
    import opa_pkg::*;
(
    input  acc_t       acc,
    input  logic [4:0] shift,
    output elem_t      res
);

    localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W+1)'(2**(DW-1) - 1);
    localparam logic signed [ACC_W:0] OUT_MIN = (ACC_W+1)'(-(2**(DW-1)));

    logic [4:0]            s;
    logic signed [ACC_W:0] wide;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] rounded;
    logic signed [ACC_W:0] shifted;

    always_comb begin
        s       = (shift > 5'(ACC_W-1)) ? 5'(ACC_W-1) : shift;
        wide    = {acc[ACC_W-1], acc};
        // Yields 2^(s-1) for s>0 and 0 for s==0 without a separate branch.
        rnd     = ({{ACC_W{1'b0}}, 1'b1} << s) >> 1;
        rounded = wide + rnd;
        shifted = rounded >>> s;
        if (shifted > OUT_MAX)
            res = {1'b0, {(DW-1){1'b1}}};
        else if (shifted < OUT_MIN)
            res = {1'b1, {(DW-1){1'b0}}};
        else
            res = shifted[DW-1:0];
`ifdef OPA_RELU_EN
        if (res[DW-1])
            res = '0;
`else
`endif
    end

endmodule

// File: rtl/outer_product_accum.sv
// Accumulates K rank-1 int8 product matrices into saturating accumulators and drains
// the requantized result row by row. Define OPA_RELU_EN to clamp negative outputs to 0.
module outer_product_accum
    import opa_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_last,
    input  elem_t [ROWS-1:0][COLS-1:0]    prod,
    input  logic [4:0]                    shift,
    output logic                          out_valid,
    input  logic                          out_ready,
    output elem_t [COLS-1:0]              out_row,
    output logic [3:0]                    out_row_idx,
    output logic                          out_last,
    output logic                          sat_flag
);

    opa_state_t                  state_q, state_d;
    acc_t [ROWS-1:0][COLS-1:0]   acc_q;
    acc_t [ROWS-1:0][COLS-1:0]   acc_sum;
    acc_t [COLS-1:0]             acc_row;
    logic [3:0]                  row_q;
    logic [4:0]                  shift_q;
    logic                        any_sat;
    logic                        in_hs;
    logic                        out_hs;
    logic                        row_end;
    sat_res_t                    r;

    assign in_ready    = !rst && (state_q != DRAIN);
    assign out_valid   = (state_q == DRAIN);
    assign in_hs       = in_valid && in_ready;
    assign out_hs      = out_valid && out_ready;
    assign row_end     = (row_q == 4'(ROWS-1));
    assign out_last    = out_valid && row_end;
    assign out_row_idx = row_q;

    always_comb begin
        any_sat = 1'b0;
        r       = '0;
        acc_sum = '0;
        for (int unsigned i = 0; i < ROWS; i++) begin
            for (int unsigned j = 0; j < COLS; j++) begin
                r             = sat_add(acc_q[i][j], sext(prod[i][j]));
                acc_sum[i][j] = r.sum;
                any_sat       = any_sat | r.ovf;
            end
        end
    end

    always_comb begin
        acc_row = acc_q[row_q];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACCUM: if (in_hs) state_d = in_last ? DRAIN : ACCUM;
            DRAIN:       if (out_hs && row_end) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            row_q    <= '0;
            shift_q  <= '0;
            sat_flag <= 1'b0;
        end else begin
            state_q <= state_d;
            if (in_hs) begin
                // First beat of a frame overwrites, so no clearing pass is needed between frames.
                if (state_q == IDLE) begin
                    for (int unsigned i = 0; i < ROWS; i++)
                        for (int unsigned j = 0; j < COLS; j++)
                            acc_q[i][j] <= sext(prod[i][j]);
                    shift_q  <= shift;
                    sat_flag <= 1'b0;
                end else begin
                    acc_q <= acc_sum;
                    if (any_sat)
                        sat_flag <= 1'b1;
                end
            end
            if (out_hs)
                row_q <= row_end ? '0 : row_q + 4'd1;
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_rq
        opa_requant u_rq (
            .acc   (acc_row[j]),
            .shift (shift_q),
            .res   (out_row[j])
        );
    end

endmodule
